// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed MULT/DIV (radix-2 Booth, restoring division) producing HI/LO.
// Optional MULTDIV_DIV0_FLAG_EN adds a sticky div_zero output.
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULTDIV_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   ah_q, ah_d;      // Booth upper accumulator (one guard bit) / division remainder
  logic [WIDTH-1:0] al_q, al_d;      // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] m_q, m_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             qm1_q, qm1_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d, fin_dz;

  logic [WIDTH:0]   booth_sum, booth_ah, div_shift, div_diff, div_ah;
  logic [WIDTH-1:0] booth_al, div_al, abs_a, abs_b;
  logic             div_ge;

  always_comb begin
    unique case ({al_q[0], qm1_q})
      2'b01:   booth_sum = ah_q + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = ah_q - {m_q[WIDTH-1], m_q};
      default: booth_sum = ah_q;
    endcase
    booth_ah = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_al = {booth_sum[0], al_q[WIDTH-1:1]};

    div_shift = {ah_q[WIDTH-1:0], al_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    div_ge    = ~div_diff[WIDTH];
    div_ah    = div_ge ? div_diff : div_shift;
    div_al    = {al_q[WIDTH-2:0], div_ge};

    // Unsigned magnitude, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ah_d    = ah_q;
    al_d    = al_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin_dz  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_mult) begin
          ah_d    = '0;
          al_d    = a;
          m_d     = b;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MULT;
        end else if (start_div) begin
          ah_d    = '0;
          al_d    = abs_a;
          m_d     = abs_b;
          qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d  = a[WIDTH-1];
          dz_d    = (b == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      MULT: begin
        ah_d  = booth_ah;
        al_d  = booth_al;
        qm1_d = al_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = booth_ah[WIDTH-1:0];
          lo_d    = booth_al;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      DIV: begin
        if (dz_q) begin
          // Rebuild the original dividend from its stored magnitude and sign.
          hi_d    = rneg_q ? -al_q : al_q;
          lo_d    = '1;
          fin_dz  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          ah_d  = div_ah;
          al_d  = div_al;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_d    = rneg_q ? -div_ah[WIDTH-1:0] : div_ah[WIDTH-1:0];
            lo_d    = qneg_q ? -div_al : div_al;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MULTDIV_DIV0_FLAG_EN
  logic div_zero_q, div_zero_d;

  always_comb begin
    div_zero_d = div_zero_q;
    if (state_q == IDLE && (start_mult || start_div)) div_zero_d = 1'b0;
    else if (fin_dz) div_zero_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_zero_q <= 1'b0;
    else          div_zero_q <= div_zero_d;
  end

  assign div_zero = div_zero_q;
`else
  logic unused_fin_dz;
  assign unused_fin_dz = fin_dz;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand-written corner sequences.
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULTDIV_DIV0_FLAG_EN
  logic        div_zero;
`endif

  int compared = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
`ifdef MULTDIV_DIV0_FLAG_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operation from IDLE, returns after the cycle following done.
  task automatic run_op(input string tag, input logic is_div, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int lat;
    int busy_bad;
    int hold_bad;
    logic [31:0] prev_hi, prev_lo;
    lat = 0; busy_bad = 0; hold_bad = 0;
    prev_hi = hi; prev_lo = lo;
    @(negedge clk);
    start_mult = !is_div; start_div = is_div; a = av; b = bv;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0; a = $urandom; b = $urandom;
`ifdef MULTDIV_DIV0_FLAG_EN
    check({tag, " div_zero cleared by start"}, {63'd0, div_zero}, 64'd0);
`endif
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (hi !== prev_hi || lo !== prev_lo) hold_bad++;
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
    check({tag, " busy during op"}, 64'(busy_bad), 64'd0);
    check({tag, " hi/lo held during op"}, 64'(hold_bad), 64'd0);
    check({tag, " busy low at done"}, {63'd0, busy}, 64'd0);
`ifdef MULTDIV_DIV0_FLAG_EN
    check({tag, " div_zero at done"}, {63'd0, div_zero}, {63'd0, (is_div && bv == 32'd0)});
`endif
    @(posedge clk); #1;
    check({tag, " done is one cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[1]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 33};
    vecs[2]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[3]  = '{1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 33};
    vecs[4]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[7]  = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
    vecs[8]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[9]  = '{1'b1, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 2};
    vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 2};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
`ifdef MULTDIV_DIV0_FLAG_EN
    check("reset div_zero", {63'd0, div_zero}, 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);
    end

`ifdef MULTDIV_DIV0_FLAG_EN
    repeat (3) @(posedge clk);
    #1;
    check("div_zero sticky after done", {63'd0, div_zero}, 64'd1);
`endif

    // Simultaneous starts, plus a start_div pulse while busy: only the multiply runs.
    begin
      int dones;
      int done_at;
      dones = 0; done_at = 0;
      @(negedge clk);
      start_mult = 1'b1; start_div = 1'b1; a = 32'd3; b = 32'd5;
      @(posedge clk); #1;
      start_mult = 1'b0; start_div = 1'b0;
      for (int k = 1; k <= 45; k++) begin
        if (done) begin
          dones++;
          if (done_at == 0) done_at = k;
        end
        if (k == 5) begin
          start_div = 1'b1; a = 32'd1000; b = 32'd10;
        end else begin
          start_div = 1'b0;
        end
        @(posedge clk); #1;
      end
      start_div = 1'b0;
      check("both starts: done count", 64'(dones), 64'd1);
      check("both starts: done cycle", 64'(done_at), 64'd33);
      check("both starts: hi", {32'd0, hi}, 64'd0);
      check("both starts: lo", {32'd0, lo}, 64'd15);
      check("both starts: idle after", {63'd0, busy}, 64'd0);
    end

    // Reset in the middle of a divide.
    begin
      int dones;
      dones = 0;
      @(negedge clk);
      start_div = 1'b1; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start_div = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid-op reset busy", {63'd0, busy}, 64'd0);
      check("mid-op reset hi", {32'd0, hi}, 64'd0);
      check("mid-op reset lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
      check("no done after abort", 64'(dones), 64'd0);
    end

    run_op("post-reset mult", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
